x_sample_feeder: RTL and testbench
==================================

Name: x_sample_feeder

Overview:
- Write-side front end for the time-multiplexed FIR datapath.
- Accepts input samples over a valid/ready stream and buffers them in a circular FIFO.
- Presents one sample on xOut each time the control unit pulses xSEL. This is the same strobe the filter uses to fetch a new x sample, once per N+1-cycle frame.
- Provides priming, underflow detection and fill-level status so the filter never consumes uninitialised data.

Parameters:
- WII, 2, integer bits of the input sample (signed fixed point).
- WFI, 6, fractional bits of the input sample.
- DEPTH, 8, FIFO depth in samples; must be a power of 2, >= 2.
- PRIME, 2, samples that must be buffered before the first pop is honoured; 1 <= PRIME <= DEPTH.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream sample valid.
- in_data  in  WII+WFI  upstream sample, signed Q(WII.WFI).
- in_ready  out  1  feeder can accept a sample this cycle.
- xSEL  in  1  single-cycle pop strobe from the control unit.
- xOut  out  WII+WFI  current sample presented to the filter (registered).
- level  out  $clog2(DEPTH)+1  number of samples stored.
- primed  out  1  high once priming is complete.
- underflow  out  1  sticky; set when xSEL is seen while RUN and empty.
- uf_count  out  8  saturating count of underflow events.

Behaviour:
- Reset: all outputs and pointers clear (xOut=0, level=0, primed=0, underflow=0, uf_count=0) and the FSM enters PRIMING. Reset applies on the clock edge and overrides all activity, including mid-stream.
- Push: in_ready = (level < DEPTH), combinational from registered level. The write occurs when in_valid && in_ready. The write pointer wraps modulo DEPTH.
- Pop: evaluated only on xSEL, and only in state RUN. If level > 0, xOut <= mem[rd_ptr] and rd_ptr advances with wrap. The new xOut is visible the cycle after the xSEL edge (1-cycle latency). xOut holds between pops.
- Simultaneous push and pop in the same cycle: level is unchanged. A full FIFO does not accept the push that cycle, because in_ready uses the pre-pop level; there is no ready bypass.
- Push and pop on an empty FIFO in the same cycle: no data bypass. The pop is treated as an underflow.
- FSM states:
  - PRIMING: xSEL ignored; xOut = 0. Go to RUN when level >= PRIME (evaluated on registered level). primed is set on entering RUN.
  - RUN: normal pops. If xSEL arrives with level == 0, go to STARVED and perform the underflow action.
  - STARVED: each xSEL performs the underflow action. Return to RUN on the first cycle level > 0. That sample is then popped on the next xSEL, so no re-priming occurs.
- Underflow action:
  - xOut <= 0.
  - underflow <= 1 (sticky until RST).
  - uf_count increments and saturates at 255.
- level: +1 on push only, -1 on successful pop only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro XFEED_HOLD_LAST_EN.
- Defined: the underflow action leaves xOut holding the last successfully popped sample instead of zeroing it. Flag and counter behaviour are unchanged. If no sample has been popped since reset, xOut remains 0.
- Undefined: xOut <= 0 on underflow, as described in Behaviour.

Test Plan:
- Reset/priming, PRIME=2: push 0x10 only, pulse xSEL -> xOut stays 0x00, primed=0. Push 0x20 -> primed=1 one cycle later. Pulse xSEL -> xOut=0x10 the next cycle, then 0x20 on the next pulse.
- Fill to full, DEPTH=8: push 0x01..0x08 -> level=8, in_ready=0. Ninth push with in_valid=1 is dropped. Pop 8 times -> 0x01..0x08 in order, level=0.
- Wrap-around: interleave 20 pushes (0x30..0x43) with pops, keeping level between 1 and 7 -> output sequence exactly 0x30..0x43, no underflow.
- Simultaneous push and pop at level=3 -> level stays 3; the popped value is the oldest. Same event at level=8 -> push refused, level=7.
- Underflow: in RUN, drain to empty, then pulse xSEL 3 times -> xOut=0x00 (or the last value under XFEED_HOLD_LAST_EN), underflow=1, uf_count=3, state STARVED. Push 0x55, pulse xSEL -> xOut=0x55, state RUN.
- Reset mid-operation at level=5 with underflow=1 -> next cycle: level=0, xOut=0, underflow=0, uf_count=0, primed=0.

Source files
------------

// File: rtl/x_sample_feeder.sv
// Circular-FIFO sample feeder for the time-multiplexed FIR: buffers an input stream and
// presents one sample on xOut per xSEL strobe. Define XFEED_HOLD_LAST_EN to hold xOut on underflow.
module x_sample_feeder #(
    parameter int WII   = 2,
    parameter int WFI   = 6,
    parameter int DEPTH = 8,
    parameter int PRIME = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              in_valid,
    input  logic signed [WII+WFI-1:0]         in_data,
    output logic                              in_ready,
    input  logic                              xSEL,
    output logic signed [WII+WFI-1:0]         xOut,
    output logic        [$clog2(DEPTH):0]     level,
    output logic                              primed,
    output logic                              underflow,
    output logic        [7:0]                 uf_count
);

    localparam int W  = WII + WFI;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {PRIMING, RUN, STARVED} state_t;

    state_t                state;
    logic signed [W-1:0]   mem [DEPTH];
    logic        [AW-1:0]  wr_ptr;
    logic        [AW-1:0]  rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  uf_event;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Ready looks only at the registered level, so a full FIFO refuses a push even when a pop coincides.
    assign in_ready = (level < LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = xSEL && (state == RUN) && (level != '0);
    assign uf_event = xSEL && (state != PRIMING) && (level == '0);

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= PRIMING;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            xOut      <= '0;
            primed    <= 1'b0;
            underflow <= 1'b0;
            uf_count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);

            if (pop) begin
                xOut   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end

            if (push && !pop)
                level <= level + LW'(1);
            else if (pop && !push)
                level <= level - LW'(1);

            // A push landing on an empty FIFO is never bypassed to the output; the strobe counts as underflow.
            if (uf_event) begin
`ifndef XFEED_HOLD_LAST_EN
                xOut <= '0;
`endif
                underflow <= 1'b1;
                uf_count  <= sat_inc(uf_count);
            end

            case (state)
                PRIMING: begin
                    if (level >= LW'(PRIME)) begin
                        state  <= RUN;
                        primed <= 1'b1;
                    end
                end
                RUN: begin
                    if (uf_event)
                        state <= STARVED;
                end
                STARVED: begin
                    if (level != '0)
                        state <= RUN;
                end
                default: state <= PRIMING;
            endcase
        end
    end

endmodule

// File: tb/tb_x_sample_feeder.sv
// Directed self-checking bench for x_sample_feeder (DEPTH=8, PRIME=2, 8-bit samples).
module tb_x_sample_feeder;

    logic       CLK = 1'b0;
    logic       RST;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       xSEL;
    logic [7:0] xOut;
    logic [3:0] level;
    logic       primed;
    logic       underflow;
    logic [7:0] uf_count;

    int checks = 0;
    int errors = 0;

`ifdef XFEED_HOLD_LAST_EN
    localparam logic [7:0] UF_OUT_A = 8'h69;
    localparam logic [7:0] UF_OUT_B = 8'h12;
`else
    localparam logic [7:0] UF_OUT_A = 8'h00;
    localparam logic [7:0] UF_OUT_B = 8'h00;
`endif

    x_sample_feeder #(.WII(2), .WFI(6), .DEPTH(8), .PRIME(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .xSEL      (xSEL),
        .xOut      (xOut),
        .level     (level),
        .primed    (primed),
        .underflow (underflow),
        .uf_count  (uf_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        xSEL = 1'b1;
        tick();
        xSEL = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        xSEL     = 1'b1;
        tick();
        in_valid = 1'b0;
        xSEL     = 1'b0;
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_data = 8'h00; xSEL = 1'b0;
        tick(); tick();
        RST = 1'b0;
        check("rst_xout", xOut, 8'h00);
        check("rst_level", level, 4'd0);
        check("rst_primed", primed, 1'b0);
        check("rst_uflag", underflow, 1'b0);
        check("rst_ufcnt", uf_count, 8'd0);
        check("rst_ready", in_ready, 1'b1);

        // Priming: one sample is not enough, strobe ignored
        push(8'h10);
        pop();
        check("prime_xout", xOut, 8'h00);
        check("prime_primed0", primed, 1'b0);
        check("prime_level1", level, 4'd1);
        check("prime_uflag", underflow, 1'b0);
        push(8'h20);
        check("prime_primed_edge", primed, 1'b0);
        tick();
        check("prime_primed1", primed, 1'b1);
        pop();
        check("prime_pop1", xOut, 8'h10);
        pop();
        check("prime_pop2", xOut, 8'h20);
        check("prime_level0", level, 4'd0);

        // Fill to full, drop ninth push, drain in order
        for (int i = 1; i <= 8; i++) push(8'(i));
        check("full_level", level, 4'd8);
        check("full_ready", in_ready, 1'b0);
        push(8'h09);
        check("full_drop", level, 4'd8);
        for (int i = 1; i <= 8; i++) begin
            pop();
            check($sformatf("drain_%0d", i), xOut, 32'(i));
        end
        check("drain_level", level, 4'd0);
        check("drain_uflag", underflow, 1'b0);

        // Wrap-around: steady level of 2 with simultaneous push/pop
        push(8'h30);
        push(8'h31);
        for (int i = 2; i < 20; i++) begin
            push_pop(8'(8'h30 + i));
            check($sformatf("wrap_out_%0d", i), xOut, 32'(8'h30 + i - 2));
            check($sformatf("wrap_lvl_%0d", i), level, 4'd2);
        end
        pop();
        check("wrap_tail1", xOut, 8'h42);
        pop();
        check("wrap_tail2", xOut, 8'h43);
        check("wrap_level", level, 4'd0);
        check("wrap_uflag", underflow, 1'b0);

        // Simultaneous push/pop at level 3 and at full
        push(8'h61); push(8'h62); push(8'h63);
        push_pop(8'h64);
        check("simul3_out", xOut, 8'h61);
        check("simul3_level", level, 4'd3);
        for (int i = 5; i <= 9; i++) push(8'(8'h60 + i));
        check("simul8_pre", level, 4'd8);
        push_pop(8'h6A);
        check("simul8_out", xOut, 8'h62);
        check("simul8_level", level, 4'd7);
        for (int i = 3; i <= 9; i++) begin
            pop();
            check($sformatf("simul_drain_%0d", i), xOut, 32'(8'h60 + i));
        end
        check("simul_level0", level, 4'd0);

        // Underflow: three strobes on an empty FIFO
        for (int i = 1; i <= 3; i++) begin
            pop();
            check($sformatf("uf_out_%0d", i), xOut, UF_OUT_A);
            check($sformatf("uf_cnt_%0d", i), uf_count, 32'(i));
        end
        check("uf_flag", underflow, 1'b1);
        push(8'h55);
        tick();
        pop();
        check("recover_out", xOut, 8'h55);
        check("recover_level", level, 4'd0);
        check("recover_ufcnt", uf_count, 8'd3);
        check("recover_flag", underflow, 1'b1);

        // Reset mid-stream at level 5 with push pending
        for (int i = 0; i < 5; i++) push(8'(8'h70 + i));
        check("mid_level", level, 4'd5);
        RST = 1'b1; in_valid = 1'b1; in_data = 8'h7F;
        tick();
        RST = 1'b0; in_valid = 1'b0;
        check("mid_rst_level", level, 4'd0);
        check("mid_rst_xout", xOut, 8'h00);
        check("mid_rst_uflag", underflow, 1'b0);
        check("mid_rst_ufcnt", uf_count, 8'd0);
        check("mid_rst_primed", primed, 1'b0);

        // Counter saturation at 255
        push(8'h11); push(8'h12); tick();
        pop(); pop();
        check("sat_last", xOut, 8'h12);
        for (int i = 0; i < 260; i++) pop();
        check("sat_ufcnt", uf_count, 8'd255);
        check("sat_out", xOut, UF_OUT_B);
        check("sat_flag", underflow, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
